// File: rtl/button_pulse_gen.sv
// Pushbutton conditioner: synchronizes a raw button, debounces it with a
// four-state FSM and emits a one-cycle load strobe per accepted press,
// plus a debounced level and a 4-bit wrapping press counter.
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       enable,
  output logic       btn_level,
  output logic [3:0] press_count
);

  // Debounce counter width; a 1-bit counter is the floor for tiny settings.
  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          accept;
  logic          raw_p;
  logic          sync1, sync2;
  logic          p;

  // Normalize polarity before the first flop so everything downstream sees 1 = pressed.
  assign raw_p = ACTIVE_LOW ? ~btn_in : btn_in;
  assign p     = sync2;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse sync1/sync2 into one stage.
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_p;
      sync2 <= sync1;
    end
  end

  // Next-state, counter and press-acceptance decode.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (p) begin
          next_state = PRESS_WAIT;
          next_cnt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          next_state = HELD;
          accept     = 1'b1;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          next_state = RELEASE_WAIT;
          next_cnt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          next_state = HELD;
        end else if (cnt == CNT_LAST) begin
          next_state = IDLE;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        // Corrupted encoding recovers to released without a strobe.
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset overrides any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      enable      <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= 4'd0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      enable      <= accept;
      btn_level   <= (next_state == HELD) || (next_state == RELEASE_WAIT);
      // Counter wraps 15 -> 0 naturally in 4 bits.
      press_count <= press_count + 4'(accept);
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: two instances (default
// parameters, and ACTIVE_LOW=0 / DEBOUNCE_CYCLES=2) driven by directed and
// random button waveforms, compared against a run-length reference model
// through an enable-pulse scoreboard.
module tb_button_pulse_gen;

  typedef struct packed {
    int unsigned edge_n;
    logic [3:0]  count;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn [2];
  logic       en  [2];
  logic       lvl [2];
  logic [3:0] cnt [2];

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // Reference model state, one slot per instance.
  int unsigned edge_idx = 0;
  bit          m_p1    [2];
  bit          m_p2    [2];
  bit          m_level [2];
  int          m_run   [2];
  logic [3:0]  m_count [2];
  exp_t        sb [2][$];

  always #5 clk = ~clk;

  button_pulse_gen #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) u0 (
    .clk(clk), .reset(reset), .btn_in(btn[0]),
    .enable(en[0]), .btn_level(lvl[0]), .press_count(cnt[0])
  );

  button_pulse_gen #(.DEBOUNCE_CYCLES(2), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .reset(reset), .btn_in(btn[1]),
    .enable(en[1]), .btn_level(lvl[1]), .press_count(cnt[1])
  );

  function automatic int deb(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic bit active_low(int i);
    return (i == 0);
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: the sampled level reaches the FSM two edges after capture;
  // the debounced level flips once DEBOUNCE_CYCLES+1 consecutive samples
  // disagree with it (the first disagreeing sample opens the wait, then
  // DEBOUNCE_CYCLES more confirm it). A flip to pressed is one enable pulse.
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_p1[i] = 0; m_p2[i] = 0; m_level[i] = 0; m_run[i] = 0; m_count[i] = 4'd0;
    end
    forever begin
      @(posedge clk);
      edge_idx++;
      for (int i = 0; i < 2; i++) begin
        bit pressed_raw;
        bit p;
        pressed_raw = active_low(i) ? !btn[i] : btn[i];
        if (reset) begin
          m_p1[i] = 0; m_p2[i] = 0; m_level[i] = 0; m_run[i] = 0; m_count[i] = 4'd0;
        end else begin
          p       = m_p2[i];
          m_p2[i] = m_p1[i];
          m_p1[i] = pressed_raw;
          m_run[i] = (p != m_level[i]) ? m_run[i] + 1 : 0;
          if (m_run[i] == deb(i) + 1) begin
            m_level[i] = !m_level[i];
            m_run[i]   = 0;
            if (m_level[i]) begin
              m_count[i] = m_count[i] + 4'd1;
              sb[i].push_back('{edge_n: edge_idx, count: m_count[i]});
            end
          end
        end
      end
    end
  end

  // Monitor: away from the active edge, pop the scoreboard whenever a pulse is
  // due and check every output against the model.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (!done) begin
        for (int i = 0; i < 2; i++) begin
          if (sb[i].size() > 0 && sb[i][0].edge_n == edge_idx) begin
            exp_t item;
            item = sb[i].pop_front();
            check($sformatf("u%0d_enable_pulse", i), 32'(en[i]), 32'd1);
            check($sformatf("u%0d_count_at_pulse", i), 32'(cnt[i]), 32'(item.count));
          end else begin
            check($sformatf("u%0d_enable_quiet", i), 32'(en[i]), 32'd0);
          end
          check($sformatf("u%0d_btn_level", i), 32'(lvl[i]), 32'(m_level[i]));
          check($sformatf("u%0d_press_count", i), 32'(cnt[i]), 32'(m_count[i]));
        end
      end
    end
  end

  task automatic drive(int i, bit pressed);
    btn[i] = active_low(i) ? !pressed : pressed;
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed scenarios, then random bouncing on both instances.
  initial begin
    int rem [2];
    bit lvl_r [2];
    drive(0, 0);
    drive(1, 0);
    reset = 1'b1;
    cycles(3);
    check("reset_enable", 32'(en[0]), 32'd0);
    check("reset_level", 32'(lvl[0]), 32'd0);
    check("reset_count", 32'(cnt[0]), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Clean press then release.
    drive(0, 1); cycles(20);
    check("clean_count", 32'(cnt[0]), 32'd1);
    check("clean_level", 32'(lvl[0]), 32'd1);
    drive(0, 0); cycles(20);
    check("release_level", 32'(lvl[0]), 32'd0);

    // Short glitch is rejected.
    drive(0, 1); cycles(3);
    drive(0, 0); cycles(20);
    check("glitch_count", 32'(cnt[0]), 32'd1);

    // Release bounce after an accepted press.
    drive(0, 1); cycles(20);
    drive(0, 0); cycles(2);
    drive(0, 1); cycles(2);
    drive(0, 0); cycles(2);
    drive(0, 1); cycles(10);
    check("bounce_level", 32'(lvl[0]), 32'd1);
    check("bounce_count", 32'(cnt[0]), 32'd2);
    drive(0, 0); cycles(20);

    // Seventeen clean presses: 2 + 17 wraps to 3.
    for (int k = 0; k < 17; k++) begin
      drive(0, 1); cycles(10);
      drive(0, 0); cycles(10);
    end
    check("wrap_count", 32'(cnt[0]), 32'd3);

    // Reset in the middle of a held press; the press is re-debounced afterwards.
    drive(0, 1); cycles(5);
    reset = 1'b1; cycles(1);
    reset = 1'b0;
    check("midreset_enable", 32'(en[0]), 32'd0);
    check("midreset_level", 32'(lvl[0]), 32'd0);
    check("midreset_count", 32'(cnt[0]), 32'd0);
    cycles(20);
    check("midreset_repress_count", 32'(cnt[0]), 32'd1);
    drive(0, 0); cycles(20);

    // Active-high instance with the shortest debounce.
    drive(1, 1); cycles(10);
    check("u1_press_count", 32'(cnt[1]), 32'd1);
    check("u1_press_level", 32'(lvl[1]), 32'd1);
    drive(1, 0); cycles(10);

    // Random bouncing runs on both instances, with occasional resets.
    rem[0] = 0; rem[1] = 0; lvl_r[0] = 0; lvl_r[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          lvl_r[i] = $urandom_range(0, 1) == 1;
          rem[i]   = $urandom_range(1, 9);
        end
        drive(i, lvl_r[i]);
        rem[i]--;
      end
      reset = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    reset = 1'b0;
    drive(0, 0); drive(1, 0);
    cycles(20);

    check("u0_scoreboard_drained", 32'(sb[0].size()), 32'd0);
    check("u1_scoreboard_drained", 32'(sb[1].size()), 32'd0);
    done = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_pulse_gen.md
BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive synchronized cycles a new button level must hold before it is accepted; legal range 2..65535.
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1; 1 means raw btn_in = 0 is "pressed", 0 means btn_in = 1 is "pressed".
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port btn_in  input  1  raw, asynchronous pushbutton level.
REQ-006 Port enable  output  1  one-cycle load strobe per accepted press; drives the enable input of the 2-bit accumulator register.
REQ-007 Port btn_level  output  1  debounced level; 1 = pressed, independent of ACTIVE_LOW.
REQ-008 Port press_count  output  4  count of accepted presses, for debug LEDs.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer; when ACTIVE_LOW = 1 it SHALL be inverted before the first flop, so the internal signal p is 1 for pressed.
REQ-010 A debounce counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide, with a minimum of 1 bit.
REQ-011 The FSM SHALL have four states: IDLE (released), PRESS_WAIT, HELD (pressed), RELEASE_WAIT.
REQ-012 In IDLE, p = 1 SHALL go to PRESS_WAIT with cnt = 0; otherwise the FSM stays in IDLE.
REQ-013 In PRESS_WAIT:
- p = 0 SHALL return to IDLE with no pulse.
- p = 1 with cnt < DEBOUNCE_CYCLES-1 SHALL increment cnt.
- p = 1 with cnt = DEBOUNCE_CYCLES-1 SHALL go to HELD.
REQ-014 In HELD, p = 0 SHALL go to RELEASE_WAIT with cnt = 0; otherwise the FSM stays in HELD.
REQ-015 In RELEASE_WAIT:
- p = 1 SHALL return to HELD with no pulse (release bounce).
- p = 0 with cnt < DEBOUNCE_CYCLES-1 SHALL increment cnt.
- p = 0 with cnt = DEBOUNCE_CYCLES-1 SHALL go to IDLE.
REQ-016 enable SHALL be a registered output, high for exactly one cycle: the first cycle after the PRESS_WAIT->HELD transition.
REQ-017 enable SHALL stay low on every other transition and for the whole time the button is held.
REQ-018 Latency: if p is first sampled pressed at edge 0 and stays pressed, enable SHALL be high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3 (edges 6..7 for the default).
REQ-019 btn_level SHALL be 1 in HELD and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-020 press_count SHALL increment in the same edge that sets enable.
REQ-021 press_count SHALL wrap from 15 to 0.
REQ-022 A pressed pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no enable and no press_count change.
REQ-023 A release shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT produce a second enable.
REQ-024 The FSM SHALL never assert enable on two consecutive cycles.
REQ-025 Any unreachable state encoding SHALL go to IDLE on the next edge with enable = 0.

Reset
REQ-026 While reset = 1 at a rising edge, the following SHALL be cleared: state to IDLE, cnt, both synchronizer flops (to released), enable, btn_level and press_count (all 0).
REQ-027 reset SHALL take priority over every FSM transition, including one due in the same edge.
REQ-028 If reset is applied mid-press and the button is still held after reset is released, the block SHALL treat it as a new press and emit one enable after the full debounce latency.

Verification
REQ-029 Clean press, default parameters, ACTIVE_LOW = 1: drive btn_in 1->0 and hold 20 cycles -> enable high exactly one cycle at edge 6 after first sample; press_count = 1; btn_level = 1 from edge 6.
REQ-030 Glitch: btn_in low for 3 synchronized cycles, then high -> enable never asserted; press_count stays 0; btn_level stays 0.
REQ-031 Release bounce: after an accepted press, toggle btn_in high 2 cycles, low 2 cycles, high 2 cycles, then low 10 cycles -> no additional enable; btn_level stays 1; press_count = 1.
REQ-032 Wrap: perform 17 clean press/release pairs -> exactly 17 single-cycle enable pulses; press_count reads 1 at the end.
REQ-033 Reset mid-operation: assert reset 1 cycle at edge 5 of a held press -> no enable at edge 6; all outputs 0; with the button still held, enable fires 6 edges after reset is released.
REQ-034 ACTIVE_LOW = 0, DEBOUNCE_CYCLES = 2: btn_in 0->1 held -> enable at edge 4; press_count = 1.
